// File: rtl/regfile_scan_display_if.sv
// Register-file test port and board display signals of the debug front end.
interface regfile_scan_display_if;
   logic [4:0]  test_addr;
   logic [31:0] test_data;
   logic [4:0]  led_addr;
   logic [7:0]  seg_an;
   logic [7:0]  seg_cat;

   modport master (
      output test_addr,
      output led_addr,
      output seg_an,
      output seg_cat,
      input  test_data
   );

   modport slave (
      input  test_addr,
      input  led_addr,
      input  seg_an,
      input  seg_cat,
      output test_data
   );
endinterface

// File: rtl/regfile_scan_display.sv
// Debug front end: button/auto-stepped register address, captured test data
// scanned out as 8 hex digits on a multiplexed 7-segment display.
module regfile_scan_display #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int SCAN_DIV        = 50000,
   parameter int AUTO_DIV        = 50000000
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   btn_next,
   input  logic                   btn_prev,
   input  logic                   auto_en,
   regfile_scan_display_if.master bus
);
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int SC_W = $clog2(SCAN_DIV + 1);
   localparam int AU_W = $clog2(AUTO_DIV + 1);
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [SC_W-1:0] SC_MAX = SC_W'(SCAN_DIV - 1);
   localparam logic [AU_W-1:0] AU_MAX = AU_W'(AUTO_DIV - 1);

   function automatic logic [6:0] hex7(input logic [3:0] d);
      case (d)
         4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
      endcase
   endfunction

   // Stage p0/p1: two-flop synchronizers, bit order {auto_en, btn_prev, btn_next}
   logic [2:0] sync_p0, sync_p1;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= {auto_en, btn_prev, btn_next};
         sync_p1 <= sync_p0;
      end
   end

   // Debounce: the stable level follows the input only after DEBOUNCE_CYCLES of disagreement
   logic [DB_W-1:0] db_cnt [2];
   logic [1:0]      stable, stable_d, step;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         stable   <= '0;
         stable_d <= '0;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         stable_d <= stable;
         for (int i = 0; i < 2; i++) begin
            if (sync_p1[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_MAX) begin
               stable[i] <= sync_p1[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   assign step = stable & ~stable_d;

   logic [AU_W-1:0] auto_cnt;
   logic            auto_tick;
   logic [4:0]      addr_q, addr_next;

   assign auto_tick = sync_p1[2] && (auto_cnt == AU_MAX);

   always_ff @(posedge clk) begin
      if (!resetn || !sync_p1[2] || (|step) || auto_tick) auto_cnt <= '0;
      else                                                 auto_cnt <= auto_cnt + AU_W'(1);
   end

   // Any button pulse overrides a coincident auto tick, even when the buttons cancel
   always_comb begin
      addr_next = addr_q;
      case (step)
         2'b01:   addr_next = addr_q + 5'd1;
         2'b10:   addr_next = addr_q - 5'd1;
         2'b11:   addr_next = addr_q;
         default: if (auto_tick) addr_next = addr_q + 5'd1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) addr_q <= '0;
      else         addr_q <= addr_next;
   end

   assign bus.test_addr = addr_q;
   assign bus.led_addr  = addr_q;

   // Stage capture/display: data_q one cycle behind test_addr, segments one more behind
   logic [SC_W-1:0] scan_cnt;
   logic [2:0]      idx, idx_next;
   logic            scan_wrap;
   logic [31:0]     data_q;

   always_comb begin
      scan_wrap = (scan_cnt == SC_MAX);
      idx_next  = scan_wrap ? idx + 3'd1 : idx;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         scan_cnt    <= '0;
         idx         <= '0;
         data_q      <= '0;
         bus.seg_an  <= 8'hFE;
         bus.seg_cat <= 8'hC0;
      end else begin
         scan_cnt    <= scan_wrap ? '0 : scan_cnt + SC_W'(1);
         idx         <= idx_next;
         data_q      <= bus.test_data;
         bus.seg_an  <= ~(8'b1 << idx_next);
         bus.seg_cat <= {1'b1, hex7(data_q[{idx_next, 2'b00} +: 4])};
      end
   end
endmodule

// File: tb/tb_regfile_scan_display.sv
// Randomized scoreboard bench for regfile_scan_display with a behavioural register-file model.
module tb_regfile_scan_display;
   localparam int DEB  = 4;
   localparam int SCAN = 2;
   localparam int AUTO = 10;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic btn_next = 1'b0;
   logic btn_prev = 1'b0;
   logic auto_en = 1'b0;

   regfile_scan_display_if bus();

   regfile_scan_display #(
      .DEBOUNCE_CYCLES(DEB),
      .SCAN_DIV(SCAN),
      .AUTO_DIV(AUTO)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .btn_next(btn_next),
      .btn_prev(btn_prev),
      .auto_en(auto_en),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rf_val(input logic [4:0] n);
      return (n == 5'd0) ? 32'h0 : 32'h1000_0000 + {27'd0, n};
   endfunction

   function automatic logic [6:0] hex7(input logic [3:0] d);
      logic [6:0] tbl [16];
      tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return tbl[d];
   endfunction

   always_comb bus.test_data = rf_val(bus.test_addr);

   // mode: 0 = any timing, 1 = exact gap since previous change, 2 = minimum gap
   typedef struct {
      logic [4:0] addr;
      int         mode;
      int         gap;
   } exp_t;

   exp_t       sb[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [4:0] model_addr = 5'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: samples on the falling edge, pops the scoreboard on every address change
   int         cyc = 0, last_chg = 0, k = 0, gap = 0, idx = 0;
   logic       rst_prev = 1'b1, seen_reset = 1'b0;
   logic [4:0] prev_addr = 5'd0, a1 = 5'd0, a2 = 5'd0;
   exp_t       e;
   logic [31:0] word;
   logic [7:0]  exp_an;

   always @(negedge clk) begin
      cyc++;
      if (!rst_prev) begin
         seen_reset = 1'b1;
         check("reset_test_addr", bus.test_addr, 32'd0);
         check("reset_led_addr", bus.led_addr, 32'd0);
         check("reset_seg_an", bus.seg_an, 32'hFE);
         check("reset_seg_cat", bus.seg_cat, 32'hC0);
         prev_addr = 5'd0; a1 = 5'd0; a2 = 5'd0; k = 0; last_chg = cyc;
      end else if (seen_reset) begin
         k++;
         if (bus.test_addr !== prev_addr) begin
            gap = cyc - last_chg;
            if (sb.size() == 0) begin
               check("unexpected_step", bus.test_addr, prev_addr);
            end else begin
               e = sb.pop_front();
               check("addr_step", bus.test_addr, e.addr);
               if (e.mode == 1)      check("step_gap", gap, e.gap);
               else if (e.mode == 2) check("step_min_gap", gap >= e.gap, 1);
            end
            last_chg  = cyc;
            prev_addr = bus.test_addr;
         end
         check("led_addr", bus.led_addr, bus.test_addr);
         idx    = (k / SCAN) % 8;
         exp_an = ~(8'b1 << idx);
         check("seg_an", bus.seg_an, exp_an);
         word = rf_val(a2);
         check("seg_cat", bus.seg_cat, {1'b1, hex7(word[idx*4 +: 4])});
         a2 = a1;
         a1 = bus.test_addr;
      end
      rst_prev = resetn;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input logic n, input logic p, input int hold, input int low);
      btn_next = n;
      btn_prev = p;
      if (hold >= DEB && (n ^ p)) begin
         model_addr = n ? model_addr + 5'd1 : model_addr - 5'd1;
         sb.push_back('{model_addr, 0, 0});
      end
      tick(hold);
      btn_next = 1'b0;
      btn_prev = 1'b0;
      tick(low);
   endtask

   task automatic drain(input int max);
      int t = 0;
      while (sb.size() != 0 && t < max) begin
         tick(1);
         t++;
      end
      check("scoreboard_drain", sb.size(), 32'd0);
   endtask

   task automatic wait_addr(input logic [4:0] v, input int max);
      int t = 0;
      while (bus.test_addr !== v && t < max) begin
         @(negedge clk);
         t++;
      end
      check("wait_addr", bus.test_addr, v);
   endtask

   initial begin
      int kind, low;
      logic b;
      tick(3);
      resetn = 1'b1;
      tick(20);

      press(1'b1, 1'b0, 2, 10);
      press(1'b1, 1'b0, 10, 10);
      tick(10);
      drain(20);
      press(1'b0, 1'b1, 6, 10);
      press(1'b0, 1'b1, 6, 10);
      press(1'b1, 1'b0, 6, 10);
      repeat (5) press(1'b1, 1'b0, 5, 9);
      tick(24);
      drain(20);
      press(1'b1, 1'b1, 8, 10);
      tick(10);

      for (int i = 0; i < 14; i++) begin
         kind = $urandom_range(0, 3);
         low  = $urandom_range(8, 12);
         case (kind)
            0: press(1'b1, 1'b0, $urandom_range(DEB, 10), low);
            1: press(1'b0, 1'b1, $urandom_range(DEB, 10), low);
            2: press(1'b1, 1'b1, $urandom_range(DEB, 10), low);
            default: begin
               b = 1'($urandom_range(0, 1));
               press(b, ~b, $urandom_range(1, DEB - 1), low);
            end
         endcase
      end
      drain(40);

      while (model_addr != 5'd30) press(1'b1, 1'b0, 5, 8);
      drain(40);

      auto_en = 1'b1;
      sb.push_back('{5'd31, 0, 0});
      sb.push_back('{5'd0, 1, AUTO});
      sb.push_back('{5'd1, 1, AUTO});
      wait_addr(5'd1, 60);
      tick(3);
      btn_prev = 1'b1;
      sb.push_back('{5'd0, 1, AUTO});
      sb.push_back('{5'd1, 1, AUTO});
      sb.push_back('{5'd2, 1, AUTO});
      tick(6);
      btn_prev = 1'b0;
      wait_addr(5'd2, 60);
      tick(1);
      auto_en = 1'b0;
      model_addr = 5'd2;
      tick(40);
      drain(1);

      while (model_addr != 5'd7) press(1'b1, 1'b0, 5, 8);
      drain(40);
      auto_en  = 1'b1;
      btn_next = 1'b1;
      tick(3);
      resetn = 1'b0;
      sb.delete();
      model_addr = 5'd0;
      tick(3);
      sb.push_back('{5'd1, 2, 2 + DEB});
      sb.push_back('{5'd2, 1, AUTO});
      model_addr = 5'd2;
      resetn = 1'b1;
      wait_addr(5'd2, 40);
      tick(1);
      btn_next = 1'b0;
      auto_en  = 1'b0;
      tick(30);
      drain(20);
      tick(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: no finish after 100000 cycles, summary not reached");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/regfile_scan_display.md
Name: regfile_scan_display

Overview:
- On-board debug front end that drives the register file's test read port and shows the selected register on an 8-digit multiplexed 7-segment display.
- Selects the register address from two debounced push-buttons, or from an auto-step timer when enabled.
- Captures the 32-bit test data and scans it out as 8 hex digits.
- Also drives 5 LEDs with the currently selected address.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive cycles a synchronized button level must be stable before it is accepted.
- SCAN_DIV, 50000: cycles each display digit stays lit before the scan advances.
- AUTO_DIV, 50000000: cycles between automatic address increments when auto_en=1.

Ports:
- clk  input  1  system clock.
- resetn  input  1  reset, synchronous, active-low.
- btn_next  input  1  asynchronous push-button, active-high; steps the address forward.
- btn_prev  input  1  asynchronous push-button, active-high; steps the address back.
- auto_en  input  1  asynchronous switch; 1 = auto-step mode.
- test_addr  output  5  register address presented to the register file test port.
- test_data  input  32  register value returned combinationally for test_addr.
- led_addr  output  5  copy of test_addr for the board LEDs.
- seg_an  output  8  digit anodes, active-low one-hot; bit0 = rightmost digit.
- seg_cat  output  8  segment cathodes, active-low, {dp,g,f,e,d,c,b,a}.

Behaviour:
- Reset: clk is the clock; resetn is synchronous, active-low. While resetn=0 at a posedge, all of the following take the value given:
  - test_addr=0, led_addr=0, data_q=0, digit index=0, all counters=0.
  - Debounced button states=0.
  - seg_an=8'hFE, seg_cat=8'hC0 (hex "0", dp off).
- Input synchronizers:
  - btn_next, btn_prev and auto_en each pass through a 2-flop synchronizer; only synchronized values are used.
  - Synchronizer flops reset to 0.
- Debounce, per button:
  - The counter clears whenever the synchronized level equals the stable state.
  - Otherwise it increments each cycle. When it reaches DEBOUNCE_CYCLES-1, the stable state takes the new level and the counter clears.
  - A 0->1 transition of the stable state produces a one-cycle step pulse. A 1->0 transition produces no pulse.
- Address update, registered, applied at the posedge where the pulse is high:
  - next pulse only: test_addr+1, 5-bit wrap (31->0).
  - prev pulse only: test_addr-1, 5-bit wrap (0->31).
  - Both pulses in the same cycle: no change.
  - An auto tick in the same cycle as any button pulse is discarded; the button result (including "no change") wins.
- Auto-step:
  - While synchronized auto_en=1, the auto counter counts 0..AUTO_DIV-1; reaching AUTO_DIV-1 produces a tick (test_addr+1 with wrap) and the counter returns to 0.
  - The counter also clears on any button pulse, and is held at 0 while auto_en=0.
- led_addr always equals test_addr (same register).
- Data capture: data_q <= test_data every cycle, one cycle of latency after test_addr settles.
- Display scan:
  - The scan counter counts 0..SCAN_DIV-1. Each wrap advances the digit index 0->1->...->7->0.
  - Every cycle, registered outputs are set as:
    - seg_an <= ~(8'b1 << idx_next).
    - seg_cat <= {1'b1, hex7(data_q[4*idx_next+3 : 4*idx_next])}.
  - idx_next is the digit index value after this cycle's update.
  - hex7 map, gfedcba active-low:
    - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
    - 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E
  - Exactly one anode is low in every cycle after reset.
- End-to-end latency:
  - test_addr change -> data_q after 1 cycle -> seg_cat after 2 cycles, for the digit currently selected.
- Reset mid-operation:
  - Any debounce, auto or scan count in progress is discarded; outputs return to their reset values at that posedge.
  - A button held through reset must complete a full debounce after reset before it produces a pulse.

Test Plan (DEBOUNCE_CYCLES=4, SCAN_DIV=2, AUTO_DIV=10; test_data modelled as a register file holding rf[n]=32'h1000_0000+n, rf[0]=0):
- Reset:
  - Hold resetn=0 for 3 cycles, then release.
  - Required: test_addr=0, led_addr=0, seg_an=FE, seg_cat=C0.
  - Then seg_an walks FD, FB, ... 7F, FE, each value lasting 2 cycles.
- Debounce and glitch rejection:
  - Pulse btn_next high for 2 cycles -> test_addr stays 0.
  - Hold it high for 10 cycles -> exactly one increment to 1.
  - Release and hold low 10 cycles -> no further change.
- Wrap-around and digit content:
  - Press btn_prev from 0 -> test_addr=31.
  - Press btn_next -> test_addr=0.
  - Step to 5 -> when seg_an=7F, seg_cat=F9 ("1"); when seg_an=FE, seg_cat=92 ("5").
- Simultaneous buttons:
  - Press btn_next and btn_prev so their debounced rising edges coincide -> test_addr unchanged.
- Auto-step:
  - auto_en=1 from test_addr=30 -> increments every 10 cycles: 31, 0, 1.
  - A btn_prev pulse landing on an auto tick -> only the decrement occurs, and the next tick comes 10 cycles later.
  - auto_en=0 -> address frozen.
- Reset mid-operation:
  - Assert resetn=0 while btn_next is held and auto_en=1, at test_addr=7 -> all outputs return to reset values.
  - No step until 4 stable cycles have elapsed after release.
